// File: rtl/id_pkg.sv
// id_pkg: shared constants and types for the MIPS R/I/J instruction decoder.
//   - INST_*  : internal decoded op codes carried on out_inst
//   - OPC_*   : primary opcode field values (inst[31:26])
//   - FN_*    : SPECIAL funct field values (inst[5:0])
//   - dec_t   : one decoded instruction (op, register fields, shamt, immediate, reserved flag)
package id_pkg;

  localparam logic [7:0] INST_INVALID = 8'h00;
  localparam logic [7:0] INST_ADDU    = 8'h01;
  localparam logic [7:0] INST_SUBU    = 8'h02;
  localparam logic [7:0] INST_AND     = 8'h03;
  localparam logic [7:0] INST_OR      = 8'h04;
  localparam logic [7:0] INST_XOR     = 8'h05;
  localparam logic [7:0] INST_NOR     = 8'h06;
  localparam logic [7:0] INST_SLL     = 8'h07;
  localparam logic [7:0] INST_SRL     = 8'h08;
  localparam logic [7:0] INST_SRA     = 8'h09;
  localparam logic [7:0] INST_SLT     = 8'h0A;
  localparam logic [7:0] INST_SLTU    = 8'h0B;
  localparam logic [7:0] INST_JR      = 8'h0C;
  localparam logic [7:0] INST_ADDIU   = 8'h10;
  localparam logic [7:0] INST_ORI     = 8'h11;
  localparam logic [7:0] INST_LUI     = 8'h12;
  localparam logic [7:0] INST_LW      = 8'h13;
  localparam logic [7:0] INST_SW      = 8'h14;
  localparam logic [7:0] INST_BEQ     = 8'h15;
  localparam logic [7:0] INST_BNE     = 8'h16;
  localparam logic [7:0] INST_J       = 8'h17;
  localparam logic [7:0] INST_JAL     = 8'h18;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_ADDIU   = 6'h09;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [7:0]  inst;
    logic [4:0]  reg_s;
    logic [4:0]  reg_t;
    logic [4:0]  reg_d;
    logic [4:0]  shift;
    logic [31:0] imm;
    logic        rsvd;
  } dec_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_decode_comb.sv
// id_decode_comb: purely combinational MIPS R/I/J decoder.
//   inst_code_i [31:0] : raw instruction word
//   dec_o              : decoded op, rs/rt/rd, shamt, extended immediate, reserved flag
// Fields a format does not use are driven to 0; unknown encodings give INST_INVALID, rsvd=1.
module id_decode_comb
  import id_pkg::*;
(
  input  logic [31:0] inst_code_i,
  output dec_t        dec_o
);

  logic [5:0]  opc;
  logic [5:0]  fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm16;
  logic [25:0] idx26;

  assign opc   = inst_code_i[31:26];
  assign rs    = inst_code_i[25:21];
  assign rt    = inst_code_i[20:16];
  assign rd    = inst_code_i[15:11];
  assign sh    = inst_code_i[10:6];
  assign fn    = inst_code_i[5:0];
  assign imm16 = inst_code_i[15:0];
  assign idx26 = inst_code_i[25:0];

  always_comb begin
    dec_o = '0;
    if (opc == OPC_SPECIAL) begin
      case (fn)
        FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
          dec_o.reg_s = rs;
          dec_o.reg_t = rt;
          dec_o.reg_d = rd;
          case (fn)
            FN_ADDU: dec_o.inst = INST_ADDU;
            FN_SUBU: dec_o.inst = INST_SUBU;
            FN_AND:  dec_o.inst = INST_AND;
            FN_OR:   dec_o.inst = INST_OR;
            FN_XOR:  dec_o.inst = INST_XOR;
            FN_NOR:  dec_o.inst = INST_NOR;
            FN_SLT:  dec_o.inst = INST_SLT;
            default: dec_o.inst = INST_SLTU;
          endcase
        end
        // Shifts take rt as source; rs is not part of the encoding.
        FN_SLL, FN_SRL, FN_SRA: begin
          dec_o.reg_t = rt;
          dec_o.reg_d = rd;
          dec_o.shift = sh;
          case (fn)
            FN_SLL:  dec_o.inst = INST_SLL;
            FN_SRL:  dec_o.inst = INST_SRL;
            default: dec_o.inst = INST_SRA;
          endcase
        end
        FN_JR: begin
          dec_o.inst  = INST_JR;
          dec_o.reg_s = rs;
        end
        default: dec_o.rsvd = 1'b1;
      endcase
    end else begin
      case (opc)
        OPC_ADDIU, OPC_LW, OPC_SW, OPC_BEQ, OPC_BNE: begin
          dec_o.reg_s = rs;
          dec_o.reg_t = rt;
          dec_o.imm   = sext16(imm16);
          case (opc)
            OPC_ADDIU: dec_o.inst = INST_ADDIU;
            OPC_LW:    dec_o.inst = INST_LW;
            OPC_SW:    dec_o.inst = INST_SW;
            OPC_BEQ:   dec_o.inst = INST_BEQ;
            default:   dec_o.inst = INST_BNE;
          endcase
        end
        OPC_ORI: begin
          dec_o.inst  = INST_ORI;
          dec_o.reg_s = rs;
          dec_o.reg_t = rt;
          dec_o.imm   = {16'h0, imm16};
        end
        OPC_LUI: begin
          dec_o.inst  = INST_LUI;
          dec_o.reg_t = rt;
          dec_o.imm   = {imm16, 16'h0};
        end
        OPC_J: begin
          dec_o.inst = INST_J;
          dec_o.imm  = {6'b0, idx26};
        end
        OPC_JAL: begin
          dec_o.inst  = INST_JAL;
          dec_o.reg_d = REG_RA;
          dec_o.imm   = {6'b0, idx26};
        end
        default: dec_o.rsvd = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/id_decode_q.sv
// id_decode_q: MIPS R/I/J decoder with a DEPTH-entry output queue.
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : drop all queued entries and any same-cycle input
//   in_valid/in_ready   : fetch-side handshake; in_inst_code, in_pc carried in
//   out_valid/out_ready : issue-side handshake on the queue head
//   out_inst, out_reg_s/t/d, out_shift, out_imm, out_rsvd, out_pc : head entry fields
// in_ready depends only on the stored count and flush, so a full queue stalls a cycle
// even when the head pops.
module id_decode_q
  import id_pkg::*;
#(
  parameter int unsigned OP_W  = 8,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst_code,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] out_inst,
  output logic [4:0]      out_reg_s,
  output logic [4:0]      out_reg_t,
  output logic [4:0]      out_reg_d,
  output logic [4:0]      out_shift,
  output logic [31:0]     out_imm,
  output logic            out_rsvd,
  output logic [PC_W-1:0] out_pc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    dec_t            dec;
    logic [PC_W-1:0] pc;
  } entry_t;

  dec_t            dec;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  entry_t          head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  id_decode_comb u_decode (
    .inst_code_i (in_inst_code),
    .dec_o       (dec)
  );

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    in_ready  = (count_q < CntW'(DEPTH)) && !flush;
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready && !flush;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{dec: dec, pc: in_pc};
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_inst  = OP_W'(head.dec.inst);
    out_reg_s = head.dec.reg_s;
    out_reg_t = head.dec.reg_t;
    out_reg_d = head.dec.reg_d;
    out_shift = head.dec.shift;
    out_imm   = head.dec.imm;
    out_rsvd  = head.dec.rsvd;
    out_pc    = head.pc;
  end

endmodule

// File: tb/tb_id_decode_q.sv
// tb_id_decode_q: self-checking bench for id_decode_q (DEPTH=2), directed scenarios plus a
// randomized run scored against a queue-based reference model of the decoder.
module tb_id_decode_q;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_rsvd;
  logic [31:0] in_inst_code, in_pc, out_imm, out_pc;
  logic [7:0]  out_inst;
  logic [4:0]  out_reg_s, out_reg_t, out_reg_d, out_shift;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  inst;
    logic [4:0]  s, t, d, sh;
    logic [31:0] imm;
    logic        rsvd;
    logic [31:0] pc;
  } exp_t;

  id_decode_q #(.OP_W(8), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst_code (in_inst_code),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_reg_s    (out_reg_s),
    .out_reg_t    (out_reg_t),
    .out_reg_d    (out_reg_d),
    .out_shift    (out_shift),
    .out_imm      (out_imm),
    .out_rsvd     (out_rsvd),
    .out_pc       (out_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t observed();
    return '{inst: out_inst, s: out_reg_s, t: out_reg_t, d: out_reg_d, sh: out_shift,
             imm: out_imm, rsvd: out_rsvd, pc: out_pc};
  endfunction

  // Reference decode straight from the instruction tables.
  function automatic exp_t ref_decode(input logic [31:0] code, input logic [31:0] pc);
    exp_t        e;
    int unsigned op, fn;
    logic [15:0] i16;
    op  = int'(code >> 26);
    fn  = int'(code & 32'h3F);
    i16 = code[15:0];
    e    = '0;
    e.pc = pc;
    if (op == 0) begin
      case (fn)
        'h21, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B: begin
          case (fn)
            'h21: e.inst = 8'h01;  'h23: e.inst = 8'h02;  'h24: e.inst = 8'h03;
            'h25: e.inst = 8'h04;  'h26: e.inst = 8'h05;  'h27: e.inst = 8'h06;
            'h2A: e.inst = 8'h0A;  default: e.inst = 8'h0B;
          endcase
          e.s = code[25:21]; e.t = code[20:16]; e.d = code[15:11];
        end
        'h00, 'h02, 'h03: begin
          e.inst = (fn == 0) ? 8'h07 : (fn == 2) ? 8'h08 : 8'h09;
          e.t = code[20:16]; e.d = code[15:11]; e.sh = code[10:6];
        end
        'h08: begin e.inst = 8'h0C; e.s = code[25:21]; end
        default: e.rsvd = 1'b1;
      endcase
    end else begin
      case (op)
        'h09, 'h23, 'h2B, 'h04, 'h05: begin
          case (op)
            'h09: e.inst = 8'h10;  'h23: e.inst = 8'h13;  'h2B: e.inst = 8'h14;
            'h04: e.inst = 8'h15;  default: e.inst = 8'h16;
          endcase
          e.s = code[25:21]; e.t = code[20:16];
          e.imm = (i16 >= 16'h8000) ? 32'(i16) + 32'hFFFF0000 : 32'(i16);
        end
        'h0D: begin e.inst = 8'h11; e.s = code[25:21]; e.t = code[20:16]; e.imm = 32'(i16); end
        'h0F: begin e.inst = 8'h12; e.t = code[20:16]; e.imm = 32'(i16) * 32'h10000; end
        'h02: begin e.inst = 8'h17; e.imm = code % 32'h0400_0000; end
        'h03: begin e.inst = 8'h18; e.d = 5'd31; e.imm = code % 32'h0400_0000; end
        default: e.rsvd = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_code();
    logic [5:0]  fns [12] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h00, 6'h02, 6'h03, 6'h2A, 6'h2B, 6'h08};
    logic [5:0]  ops [9]  = '{6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [31:0] w;
    int unsigned sel;
    w   = $urandom;
    sel = $urandom_range(0, 7);
    if (sel < 3) begin
      w[31:26] = 6'h00;
      w[5:0]   = fns[$urandom_range(0, 11)];
    end else if (sel < 6) begin
      w[31:26] = ops[$urandom_range(0, 8)];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst_code = '0; in_pc = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (observed() !== exp_t'(0)) begin
      bad++; $display("FAIL reset_out_data got=%h want=0", observed());
    end
    tick();
  endtask

  // Single instruction into an empty queue with out_ready high: visible next cycle, gone after.
  task automatic test_single(input string name, input logic [31:0] code, input logic [31:0] pc,
                             input exp_t want);
    exp_t got;
    out_ready = 1'b1; in_valid = 1'b1; in_inst_code = code; in_pc = pc;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready got=%b want=1", name, in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b want=1", name, out_valid); end
    got = observed();
    total++;
    if (got !== want) begin bad++; $display("FAIL %s_fields got=%h want=%h", name, got, want); end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_drain got=%b want=0", name, out_valid); end
  endtask

  task automatic test_decode_vectors();
    test_single("addu", 32'h00221821, 32'h100,
                '{inst: 8'h01, s: 5'd1, t: 5'd2, d: 5'd3, sh: 5'd0, imm: 32'h0, rsvd: 1'b0,
                  pc: 32'h100});
    test_single("sll", 32'h00031100, 32'h104,
                '{inst: 8'h07, s: 5'd0, t: 5'd3, d: 5'd2, sh: 5'd4, imm: 32'h0, rsvd: 1'b0,
                  pc: 32'h104});
    test_single("addiu", 32'h2404FFFF, 32'h108,
                '{inst: 8'h10, s: 5'd0, t: 5'd4, d: 5'd0, sh: 5'd0, imm: 32'hFFFFFFFF,
                  rsvd: 1'b0, pc: 32'h108});
    test_single("ori", 32'h3404FFFF, 32'h10C,
                '{inst: 8'h11, s: 5'd0, t: 5'd4, d: 5'd0, sh: 5'd0, imm: 32'h0000FFFF,
                  rsvd: 1'b0, pc: 32'h10C});
    test_single("jal", 32'h0C000040, 32'h110,
                '{inst: 8'h18, s: 5'd0, t: 5'd0, d: 5'd31, sh: 5'd0, imm: 32'h00000040,
                  rsvd: 1'b0, pc: 32'h110});
    test_single("lui", 32'h3C058001, 32'h114,
                '{inst: 8'h12, s: 5'd0, t: 5'd5, d: 5'd0, sh: 5'd0, imm: 32'h80010000,
                  rsvd: 1'b0, pc: 32'h114});
    test_single("rsvd", 32'hFC000000, 32'h118,
                '{inst: 8'h00, s: 5'd0, t: 5'd0, d: 5'd0, sh: 5'd0, imm: 32'h0, rsvd: 1'b1,
                  pc: 32'h118});
  endtask

  task automatic test_back_pressure();
    exp_t ea, eb, ec;
    ea = ref_decode(32'h00221821, 32'h200);
    eb = ref_decode(32'h2404FFFF, 32'h204);
    ec = ref_decode(32'h0C000040, 32'h208);
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst_code = 32'h00221821; in_pc = 32'h200;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_a got=%b want=1", in_ready); end
    tick();
    in_inst_code = 32'h2404FFFF; in_pc = 32'h204;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_b got=%b want=1", in_ready); end
    tick();
    in_inst_code = 32'h0C000040; in_pc = 32'h208;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", in_ready); end
      total++;
      if (out_valid !== 1'b1 || observed() !== ea) begin
        bad++; $display("FAIL bp_hold_a got=%b/%h want=1/%h", out_valid, observed(), ea);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_pop got=%b want=0", in_ready); end
    tick();
    #1;
    total++;
    if (observed() !== eb) begin bad++; $display("FAIL bp_b got=%h want=%h", observed(), eb); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || observed() !== ec) begin
      bad++; $display("FAIL bp_c got=%b/%h want=1/%h", out_valid, observed(), ec);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_flush();
    exp_t ed;
    ed = ref_decode(32'h8C430010, 32'h30C);
    out_ready = 1'b1; in_valid = 1'b1; in_inst_code = 32'h00851025; in_pc = 32'h300;
    tick();
    out_ready = 1'b0; in_inst_code = 32'h00A62023; in_pc = 32'h304;
    tick();
    in_inst_code = 32'h00C73826; in_pc = 32'h308;
    tick();
    in_inst_code = 32'h08000123; in_pc = 32'h30A;
    flush = 1'b1; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b want=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b want=0", out_valid); end
    in_valid = 1'b1; in_inst_code = 32'h8C430010; in_pc = 32'h30C;
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || observed() !== ed) begin
      bad++; $display("FAIL flush_after got=%b/%h want=1/%h", out_valid, observed(), ed);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_inst_code = 32'h00221821; in_pc = 32'h400;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
    total++;
    if (observed() !== exp_t'(0)) begin
      bad++; $display("FAIL rst_mid_data got=%h want=0", observed());
    end
    rst = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_after got=%b%b want=01", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        got;
    logic        want_ready, acc, pop;
    logic [31:0] code, pc;
    for (int c = 0; c < 600; c++) begin
      code = rand_code();
      pc   = $urandom;
      in_valid = 1'(($urandom_range(0, 3)) != 0);
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 24) == 0);
      in_inst_code = code; in_pc = pc;
      #1;
      want_ready = (q.size() < DEPTH) && !flush;
      total++;
      if (in_ready !== want_ready) begin
        bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", c, in_ready, want_ready);
      end
      total++;
      if (out_valid !== (q.size() != 0)) begin
        bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", c, out_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        got = observed();
        total++;
        if (got !== q[0]) begin
          bad++; $display("FAIL rnd_head cyc=%0d got=%h want=%h", c, got, q[0]);
        end
      end
      acc = in_valid && want_ready;
      pop = (q.size() != 0) && out_ready && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(ref_decode(code, pc));
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode_vectors();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
